xyolo_write: RTL and testbench
==============================

Name: xyolo_write

Overview:
- Output-side counterpart of the weight/bias fetch unit. It takes the datapath result stream one DATAPATH_W word at a time and packs DATABUS_W/DATAPATH_W words into each databus line.
- Packed lines are buffered in a small FIFO and written to consecutive external-memory addresses over the native databus interface. That interface feeds the same merge/DMA path the read unit uses.
- The CPU configures the block through request-only register writes. A run pulse starts a transfer; done flags completion.

Parameters:
- DATAPATH_W, 32, width of one stream word.
- DATABUS_W, 256, width of one databus line; must be an integer multiple of DATAPATH_W. K = DATABUS_W/DATAPATH_W.
- FIFO_ADDR_W, 2, log2 of the line FIFO depth (default depth 4).

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- clear  in  1  synchronous clear of the configuration registers only.
- run  in  1  start pulse.
- done  out  1  high when idle/complete.
- valid  in  1  CPU config request.
- addr  in  `XYOLO_WRITE_ADDR_W  config register select.
- wdata  in  `IO_ADDR_W  config value.
- wstrb  in  1  write qualifier.
- flow_in_valid  in  1  stream word valid.
- flow_in_data  in  DATAPATH_W  stream word.
- flow_in_ready  out  1  stream word accepted when valid&ready.
- databus_valid  out  1  write request.
- databus_ready  in  1  request accepted.
- databus_addr  out  `IO_ADDR_W  byte address.
- databus_wdata  out  DATABUS_W  line data.
- databus_wstrb  out  DATABUS_W/8  byte strobes.
- dma_len  out  `AXI_LEN_W  beats per burst for the DMA.

Behaviour:
- Config writes happen when valid&wstrb:
  - CONF_EXT_ADDR → ext_addr.
  - CONF_NLINES → nlines, width `MEM_ADDR_W.
  - CONF_LEN → len, width `AXI_LEN_W.
  - Unknown addresses are ignored.
  - rst or clear zeroes all three on the next edge.
- run in IDLE with nlines≠0 copies ext_addr, nlines and len into shadows, zeroes the counters and enters BUSY on the next edge. run in BUSY is ignored. run with nlines=0 leaves the block in IDLE with done=1.
- dma_len = len_shadow.
- Reset values:
  - done=1, flow_in_ready=0, databus_valid=0.
  - databus_addr=0, databus_wdata=0.
  - databus_wstrb is all-ones constant.
  - FIFO empty; pack index 0; shadows 0.
- Packer:
  - flow_in_ready = BUSY & !fifo_full & (words_in < nlines_shadow*K).
  - Word j of a line (j=0..K-1) goes to bits [DATABUS_W-1-j*DATAPATH_W -: DATAPATH_W], i.e. the first word is in the MSB slice.
  - On the accept of word K-1 the completed line is pushed into the FIFO in the same cycle and the pack index wraps to 0.
  - A full FIFO blocks acceptance of any word, including mid-line words.
- Writer FSM:
  - IDLE: entered on reset, or when lines_out reaches nlines_shadow. Goes to BUSY on run as described above.
  - BUSY: databus_valid = !fifo_empty. databus_wdata is the FIFO head (first-word-fall-through). databus_addr = ext_addr_shadow + lines_out*(DATABUS_W/8).
  - While valid&!ready, addr and wdata stay stable and valid stays high.
  - On valid&ready: pop, increment lines_out.
  - Accept of the last line: the next edge returns to IDLE and done=1.
  - Packer push and writer pop in the same cycle are legal; occupancy is unchanged.
- Timing:
  - Latency from the accept of the last word of a line to databus_valid for that line is 1 cycle when the FIFO was empty.
  - Throughput is 1 line per cycle when databus_ready is held high.
- Address arithmetic is modulo 2^`IO_ADDR_W; the address wraps silently.
- rst mid-operation: the next edge applies the reset values. Any pending databus request is dropped with no handshake.

Decomposition:
- Shared header xyolo_write.vh holds:
  - `XYOLO_WRITE_ADDR_W.
  - CONF_EXT_ADDR=0, CONF_NLINES=1, CONF_LEN=2.
  - FSM state encodings IDLE=0, BUSY=1.
- Existing xversat.vh / axi_dma.vh supply `IO_ADDR_W, `MEM_ADDR_W, `AXI_LEN_W.
- One sub-module, xyolo_write_fifo: synchronous FIFO with first-word-fall-through, DATA_W=DATABUS_W, ADDR_W=FIFO_ADDR_W, and full/empty outputs.

Test Plan:
- Basic: ext_addr=0x1000, nlines=2, len=2, run, words 0..15 with ready high → two writes.
  - Write 1: addr 0x1000, wdata 0x00000000_00000001_..._00000007.
  - Write 2: addr 0x1020, wdata words 8..15.
  - dma_len=2; done rises 1 cycle after the second handshake.
- Backpressure: nlines=6, databus_ready low, stream always valid → exactly 32 words accepted, then flow_in_ready=0 and databus_valid held high with addr/wdata stable. Release ready → remaining 16 words accepted, 6 writes in address order, done=1.
- Zero length: nlines=0, run → done stays 1, no databus_valid, flow_in_ready stays 0.
- Run while busy: nlines=2, run; second run pulse after 3 words → ignored; still exactly 2 writes at the original addresses.
- Reset mid-op: rst asserted during a stalled request → next edge databus_valid=0, done=1, FIFO empty; a new run with nlines=1 writes exactly one line.
- Clear: write ext_addr=0x2000, pulse clear, nlines=1, run → write lands at addr 0x0000.

Source files
------------

// File: rtl/xyolo_write_pkg.sv
// xyolo_write_pkg
//   Shared constants and types for the xyolo_write output unit.
//   - Address/length widths of the surrounding Versat/DMA system.
//   - Configuration register map (CONF_*), decoded on valid & wstrb.
//   - Writer FSM state encoding.
//   - idx_width(): width of a counter that indexes K words (at least 1 bit).
package xyolo_write_pkg;

    localparam int IO_ADDR_W          = 32;
    localparam int MEM_ADDR_W         = 16;
    localparam int AXI_LEN_W          = 8;
    localparam int XYOLO_WRITE_ADDR_W = 2;

    localparam logic [XYOLO_WRITE_ADDR_W-1:0] CONF_EXT_ADDR = 2'd0;
    localparam logic [XYOLO_WRITE_ADDR_W-1:0] CONF_NLINES   = 2'd1;
    localparam logic [XYOLO_WRITE_ADDR_W-1:0] CONF_LEN      = 2'd2;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    function automatic int idx_width(input int k);
        return (k > 1) ? $clog2(k) : 1;
    endfunction

endpackage

// File: rtl/xyolo_write_fifo.sv
// xyolo_write_fifo
//   Synchronous first-word-fall-through FIFO holding packed databus lines.
//   Ports:
//     clk, rst         clock, synchronous active-high reset (empties FIFO)
//     push, push_data  write side; a push while full is dropped
//     pop              read side; a pop while empty is ignored
//     pop_data         current head, valid whenever empty is low
//     full, empty      occupancy flags
//   Push and pop in the same cycle leave the occupancy unchanged.
module xyolo_write_fifo #(
    parameter int DATA_W = 256,
    parameter int ADDR_W = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    output logic [DATA_W-1:0] pop_data,
    output logic              full,
    output logic              empty
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];
    // One extra pointer bit distinguishes full from empty when the
    // low bits are equal.
    logic [ADDR_W:0]   wr_ptr;
    logic [ADDR_W:0]   rd_ptr;
    logic              do_push;
    logic              do_pop;

    assign empty    = (wr_ptr == rd_ptr);
    assign full     = (wr_ptr[ADDR_W] != rd_ptr[ADDR_W]) &&
                      (wr_ptr[ADDR_W-1:0] == rd_ptr[ADDR_W-1:0]);
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign pop_data = mem[rd_ptr[ADDR_W-1:0]];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + (ADDR_W+1)'(1);
            if (do_pop)  rd_ptr <= rd_ptr + (ADDR_W+1)'(1);
        end
    end

    // Storage carries no reset; the head is only consumed when !empty.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[ADDR_W-1:0]] <= push_data;
    end

endmodule

// File: rtl/xyolo_write.sv
// xyolo_write
//   Output-side stream-to-databus writer. Packs DATABUS_W/DATAPATH_W stream
//   words into each databus line (first word in the MSB slice), buffers lines
//   in a small FWFT FIFO and writes them to consecutive external addresses.
//   Ports:
//     clk, rst        clock, synchronous active-high reset
//     clear           zeroes the configuration registers only
//     run, done       start pulse / idle-or-complete flag
//     valid, addr, wdata, wstrb   CPU config writes (taken on valid & wstrb)
//     flow_in_*       input stream (valid/ready)
//     databus_*       native databus write request (valid/ready)
//     dma_len         burst length for the DMA (latched len)
//
//   Handshakes: a transfer happens on a rising edge where valid and ready
//   are both high. A source holding valid without ready keeps its payload
//   stable; ready never depends combinationally on the sink's own valid.
module xyolo_write
    import xyolo_write_pkg::*;
#(
    parameter int DATAPATH_W  = 32,
    parameter int DATABUS_W   = 256,
    parameter int FIFO_ADDR_W = 2
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          clear,
    input  logic                          run,
    output logic                          done,
    input  logic                          valid,
    input  logic [XYOLO_WRITE_ADDR_W-1:0] addr,
    input  logic [IO_ADDR_W-1:0]          wdata,
    input  logic                          wstrb,
    input  logic                          flow_in_valid,
    input  logic [DATAPATH_W-1:0]         flow_in_data,
    output logic                          flow_in_ready,
    output logic                          databus_valid,
    input  logic                          databus_ready,
    output logic [IO_ADDR_W-1:0]          databus_addr,
    output logic [DATABUS_W-1:0]          databus_wdata,
    output logic [DATABUS_W/8-1:0]        databus_wstrb,
    output logic [AXI_LEN_W-1:0]          dma_len
);

    localparam int K          = DATABUS_W / DATAPATH_W;
    localparam int IDX_W      = idx_width(K);
    localparam int WCNT_W     = MEM_ADDR_W + IDX_W + 1;
    localparam int LINE_BYTES = DATABUS_W / 8;

    // Configuration registers
    logic [IO_ADDR_W-1:0]  ext_addr;
    logic [MEM_ADDR_W-1:0] nlines;
    logic [AXI_LEN_W-1:0]  len;

    // Values frozen at run so CPU writes during a transfer have no effect
    logic [IO_ADDR_W-1:0]  ext_addr_shadow;
    logic [MEM_ADDR_W-1:0] nlines_shadow;
    logic [AXI_LEN_W-1:0]  len_shadow;

    state_t                state_q;
    state_t                state_d;

    logic [WCNT_W-1:0]     words_in;
    logic [WCNT_W-1:0]     words_total;
    logic [MEM_ADDR_W-1:0] lines_out;
    logic [MEM_ADDR_W-1:0] lines_out_next;
    logic [IDX_W-1:0]      pack_idx;
    logic [DATABUS_W-1:0]  line_buf;
    logic [DATABUS_W-1:0]  pack_line;

    logic                  busy;
    logic                  start;
    logic                  accept;
    logic                  last_word;
    logic                  push;
    logic                  pop;
    logic                  last_line;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic [DATABUS_W-1:0]  fifo_head;

    // ------------------------------------------------------------------
    // Configuration registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            ext_addr <= '0;
            nlines   <= '0;
            len      <= '0;
        end else if (valid && wstrb) begin
            case (addr)
                CONF_EXT_ADDR: ext_addr <= wdata;
                CONF_NLINES:   nlines   <= wdata[MEM_ADDR_W-1:0];
                CONF_LEN:      len      <= wdata[AXI_LEN_W-1:0];
                default: ;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Control decode
    // ------------------------------------------------------------------
    assign busy        = (state_q == BUSY);
    assign start       = (state_q == IDLE) && run && (nlines != '0);
    assign words_total = WCNT_W'(nlines_shadow) * WCNT_W'(K);

    // A full FIFO stalls every word, not just line-completing ones, so a
    // partially packed line never has to be held against a pending push.
    assign flow_in_ready = busy && !fifo_full && (words_in < words_total);
    assign accept        = flow_in_valid && flow_in_ready;
    assign last_word     = (pack_idx == IDX_W'(K - 1));
    assign push          = accept && last_word;

    assign databus_valid  = busy && !fifo_empty;
    assign pop            = databus_valid && databus_ready;
    assign lines_out_next = lines_out + MEM_ADDR_W'(1);
    assign last_line      = pop && (lines_out_next == nlines_shadow);

    // ------------------------------------------------------------------
    // Packer: insert the incoming word into its slice; word 0 lands in the
    // most significant slice. The completed line goes straight to the FIFO.
    // ------------------------------------------------------------------
    always_comb begin
        pack_line = line_buf;
        for (int j = 0; j < K; j++) begin
            if (pack_idx == IDX_W'(j)) begin
                pack_line[DATABUS_W-1-j*DATAPATH_W -: DATAPATH_W] = flow_in_data;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            line_buf <= '0;
        end else if (accept) begin
            line_buf <= pack_line;
        end
    end

    // ------------------------------------------------------------------
    // Shadows and counters
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            ext_addr_shadow <= '0;
            nlines_shadow   <= '0;
            len_shadow      <= '0;
            words_in        <= '0;
            lines_out       <= '0;
            pack_idx        <= '0;
        end else if (start) begin
            ext_addr_shadow <= ext_addr;
            nlines_shadow   <= nlines;
            len_shadow      <= len;
            words_in        <= '0;
            lines_out       <= '0;
            pack_idx        <= '0;
        end else begin
            if (accept) begin
                words_in <= words_in + WCNT_W'(1);
                pack_idx <= last_word ? '0 : pack_idx + IDX_W'(1);
            end
            if (pop) begin
                lines_out <= lines_out_next;
            end
        end
    end

    // ------------------------------------------------------------------
    // Writer FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (start) state_d = BUSY;
            BUSY: if (last_line) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign done = (state_q == IDLE);

    // ------------------------------------------------------------------
    // Line FIFO
    // ------------------------------------------------------------------
    xyolo_write_fifo #(
        .DATA_W (DATABUS_W),
        .ADDR_W (FIFO_ADDR_W)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (pack_line),
        .pop       (pop),
        .pop_data  (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    // ------------------------------------------------------------------
    // Databus outputs. The address wraps modulo 2^IO_ADDR_W. Data is forced
    // to zero when no request is pending so the uninitialised FIFO storage
    // never shows on the bus.
    // ------------------------------------------------------------------
    assign databus_addr  = ext_addr_shadow +
                           IO_ADDR_W'(lines_out) * IO_ADDR_W'(LINE_BYTES);
    assign databus_wdata = databus_valid ? fifo_head : '0;
    assign databus_wstrb = '1;
    assign dma_len       = len_shadow;

endmodule

// File: tb/tb_xyolo_write.sv
// tb_xyolo_write
//   Bench for xyolo_write: clock/reset, config/run driver tasks, a stream
//   source, and a databus scoreboard fed by expected lines queued at run.
module tb_xyolo_write;
    import xyolo_write_pkg::*;

    localparam int DP_W = 32;
    localparam int DB_W = 256;
    localparam int K    = DB_W / DP_W;

    logic                          clk;
    logic                          rst;
    logic                          clear;
    logic                          run;
    logic                          done;
    logic                          valid;
    logic [XYOLO_WRITE_ADDR_W-1:0] addr;
    logic [IO_ADDR_W-1:0]          wdata;
    logic                          wstrb;
    logic                          flow_in_valid;
    logic [DP_W-1:0]               flow_in_data;
    logic                          flow_in_ready;
    logic                          databus_valid;
    logic                          databus_ready;
    logic [IO_ADDR_W-1:0]          databus_addr;
    logic [DB_W-1:0]               databus_wdata;
    logic [DB_W/8-1:0]             databus_wstrb;
    logic [AXI_LEN_W-1:0]          dma_len;

    xyolo_write #(
        .DATAPATH_W  (DP_W),
        .DATABUS_W   (DB_W),
        .FIFO_ADDR_W (2)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .clear         (clear),
        .run           (run),
        .done          (done),
        .valid         (valid),
        .addr          (addr),
        .wdata         (wdata),
        .wstrb         (wstrb),
        .flow_in_valid (flow_in_valid),
        .flow_in_data  (flow_in_data),
        .flow_in_ready (flow_in_ready),
        .databus_valid (databus_valid),
        .databus_ready (databus_ready),
        .databus_addr  (databus_addr),
        .databus_wdata (databus_wdata),
        .databus_wstrb (databus_wstrb),
        .dma_len       (dma_len)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- check / report ----------------
    int checks   = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [DB_W-1:0] got,
                         input logic [DB_W-1:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // ---------------- scoreboard ----------------
    logic [IO_ADDR_W-1:0] exp_addr_q[$];
    logic [DB_W-1:0]      exp_q[$];
    int writes_seen   = 0;
    int writes_pushed = 0;

    always @(negedge clk) begin
        if (!rst && databus_valid && databus_ready) begin
            writes_seen++;
            if (exp_q.size() == 0) begin
                check("extra_write", writes_seen, writes_pushed);
            end else begin
                check("wr_addr", databus_addr, exp_addr_q.pop_front());
                check("wr_data", databus_wdata, exp_q.pop_front());
                check("wr_strb", databus_wstrb, {(DB_W/8){1'b1}});
            end
        end
    end

    // ---------------- stream source ----------------
    logic [DP_W-1:0] stream_base = '0;
    int  stream_lim = 0;
    int  word_cnt   = 0;
    bit  stream_en  = 1'b0;
    bit  acc;

    initial begin
        flow_in_valid = 1'b0;
        flow_in_data  = '0;
        forever begin
            @(negedge clk);
            acc = flow_in_valid && flow_in_ready && !rst;
            @(posedge clk);
            #1;
            if (acc) word_cnt++;
            flow_in_valid = stream_en && (word_cnt < stream_lim);
            flow_in_data  = stream_base + DP_W'(word_cnt);
        end
    end

    // ---------------- driver tasks (start/end at posedge+1) ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cfg_write(input logic [XYOLO_WRITE_ADDR_W-1:0] a,
                             input logic [IO_ADDR_W-1:0] d);
        valid = 1'b1; wstrb = 1'b1; addr = a; wdata = d;
        tick();
        valid = 1'b0; wstrb = 1'b0;
    endtask

    task automatic pulse_run();
        run = 1'b1;
        tick();
        run = 1'b0;
    endtask

    task automatic start_stream(input logic [DP_W-1:0] base, input int lim);
        stream_base   = base;
        stream_lim    = lim;
        word_cnt      = 0;
        stream_en     = 1'b1;
        flow_in_valid = (lim > 0);
        flow_in_data  = base;
    endtask

    task automatic stop_stream();
        stream_en     = 1'b0;
        flow_in_valid = 1'b0;
    endtask

    // Queue the lines a run should produce: word j of line l is base+l*K+j,
    // with word 0 in the top slice.
    task automatic expect_lines(input logic [IO_ADDR_W-1:0] ext, input int n,
                                input logic [DP_W-1:0] base);
        logic [DB_W-1:0]      line;
        logic [IO_ADDR_W-1:0] a;
        for (int l = 0; l < n; l++) begin
            line = '0;
            for (int j = 0; j < K; j++) begin
                line = {line[DB_W-DP_W-1:0], base + DP_W'(l * K + j)};
            end
            a = ext + IO_ADDR_W'(l * (DB_W / 8));
            exp_addr_q.push_back(a);
            exp_q.push_back(line);
            writes_pushed++;
        end
    endtask

    // Wait for all queued writes; done must still be low as the final
    // handshake is presented and high one edge later.
    task automatic wait_last_write(input string tag, input int budget);
        int i = 0;
        while (writes_seen < writes_pushed && i < budget) begin
            @(negedge clk);
            #1;
            i++;
        end
        check({tag, "_writes"}, writes_seen, writes_pushed);
        check({tag, "_done_pre"}, done, 1'b0);
        tick();
        check({tag, "_done"}, done, 1'b1);
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #200000;
        failures++;
        $display("FAIL watchdog got=timeout exp=finish");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    // ---------------- test sequence ----------------
    logic [DB_W-1:0] held_data;
    int  n;
    bit  saw_notdone, saw_valid, saw_ready;

    initial begin
        rst = 1'b1; clear = 1'b0; run = 1'b0;
        valid = 1'b0; addr = '0; wdata = '0; wstrb = 1'b0;
        databus_ready = 1'b0;
        repeat (3) tick();

        // Reset state
        check("rst_done", done, 1'b1);
        check("rst_flow_ready", flow_in_ready, 1'b0);
        check("rst_db_valid", databus_valid, 1'b0);
        check("rst_db_addr", databus_addr, '0);
        check("rst_db_wdata", databus_wdata, '0);
        check("rst_db_wstrb", databus_wstrb, {(DB_W/8){1'b1}});
        check("rst_dma_len", dma_len, '0);
        rst = 1'b0;
        tick();

        // Basic: two lines at 0x1000
        cfg_write(CONF_EXT_ADDR, 32'h1000);
        cfg_write(CONF_NLINES, 32'd2);
        cfg_write(CONF_LEN, 32'd2);
        expect_lines(32'h1000, 2, 32'h0);
        databus_ready = 1'b1;
        start_stream(32'h0, 16);
        pulse_run();
        check("basic_dma_len", dma_len, 8'd2);
        check("basic_busy", done, 1'b0);
        wait_last_write("basic", 200);
        check("basic_words", word_cnt, 16);

        // Backpressure: six lines, bus stalled until the FIFO fills
        databus_ready = 1'b0;
        cfg_write(CONF_EXT_ADDR, 32'h4000);
        cfg_write(CONF_NLINES, 32'd6);
        expect_lines(32'h4000, 6, 32'h100);
        start_stream(32'h100, 48);
        pulse_run();
        repeat (40) tick();
        check("bp_words_stalled", word_cnt, 32);
        check("bp_flow_ready", flow_in_ready, 1'b0);
        check("bp_db_valid", databus_valid, 1'b1);
        check("bp_db_addr", databus_addr, 32'h4000);
        check("bp_db_wdata", databus_wdata, exp_q[0]);
        held_data = databus_wdata;
        repeat (5) tick();
        check("bp_valid_held", databus_valid, 1'b1);
        check("bp_addr_held", databus_addr, 32'h4000);
        check("bp_wdata_held", databus_wdata, held_data);
        check("bp_words_still", word_cnt, 32);
        databus_ready = 1'b1;
        wait_last_write("bp", 300);
        check("bp_words", word_cnt, 48);

        // Zero length
        cfg_write(CONF_NLINES, 32'd0);
        start_stream(32'h300, 8);
        pulse_run();
        saw_notdone = 1'b0; saw_valid = 1'b0; saw_ready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (!done) saw_notdone = 1'b1;
            if (databus_valid) saw_valid = 1'b1;
            if (flow_in_ready) saw_ready = 1'b1;
            tick();
        end
        check("zero_done_low", saw_notdone, 1'b0);
        check("zero_db_valid", saw_valid, 1'b0);
        check("zero_flow_ready", saw_ready, 1'b0);
        check("zero_words", word_cnt, 0);
        stop_stream();
        tick();

        // Run while busy is ignored; shadowed address survives a config write
        cfg_write(CONF_EXT_ADDR, 32'h8000);
        cfg_write(CONF_NLINES, 32'd2);
        expect_lines(32'h8000, 2, 32'h400);
        start_stream(32'h400, 16);
        pulse_run();
        n = 0;
        while (word_cnt < 3 && n < 50) begin tick(); n++; end
        check("rwb_reach3", (word_cnt >= 3), 1'b1);
        cfg_write(CONF_EXT_ADDR, 32'h9000);
        pulse_run();
        wait_last_write("rwb", 200);
        repeat (20) tick();
        check("rwb_no_extra", writes_seen, writes_pushed);
        check("rwb_idle", done, 1'b1);
        check("rwb_words", word_cnt, 16);

        // Reset during a stalled request
        databus_ready = 1'b0;
        cfg_write(CONF_EXT_ADDR, 32'h3000);
        cfg_write(CONF_NLINES, 32'd2);
        start_stream(32'h500, 16);
        pulse_run();
        n = 0;
        while (flow_in_ready && n < 60) begin tick(); n++; end
        check("mrst_pre_valid", databus_valid, 1'b1);
        stop_stream();
        rst = 1'b1;
        tick();
        check("mrst_db_valid", databus_valid, 1'b0);
        check("mrst_done", done, 1'b1);
        check("mrst_flow_ready", flow_in_ready, 1'b0);
        check("mrst_db_addr", databus_addr, '0);
        rst = 1'b0;
        tick();
        check("mrst_dma_len", dma_len, '0);
        cfg_write(CONF_EXT_ADDR, 32'h5000);
        cfg_write(CONF_NLINES, 32'd1);
        databus_ready = 1'b1;
        expect_lines(32'h5000, 1, 32'h600);
        start_stream(32'h600, 8);
        pulse_run();
        wait_last_write("mrst", 100);
        check("mrst_words", word_cnt, 8);

        // Clear zeroes the configuration
        cfg_write(CONF_EXT_ADDR, 32'h2000);
        cfg_write(CONF_LEN, 32'd7);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        cfg_write(CONF_NLINES, 32'd1);
        expect_lines(32'h0, 1, 32'h700);
        start_stream(32'h700, 8);
        pulse_run();
        check("clr_dma_len", dma_len, '0);
        wait_last_write("clr", 100);

        // Address wraps modulo 2^IO_ADDR_W
        cfg_write(CONF_EXT_ADDR, 32'hFFFF_FFE0);
        cfg_write(CONF_NLINES, 32'd2);
        cfg_write(CONF_LEN, 32'd5);
        expect_lines(32'hFFFF_FFE0, 2, 32'h800);
        start_stream(32'h800, 16);
        pulse_run();
        check("wrap_dma_len", dma_len, 8'd5);
        wait_last_write("wrap", 200);

        repeat (5) tick();
        check("final_sb_empty", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
